// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/ack data-memory bus, stalls the pipeline
// until ack or timeout, formats load data and forwards WB controls to MEM/WB.
//   state | meaning
//   IDLE  | no access in flight; launch request on aligned load/store
//   REQ   | request on the bus, waiting for ack or timeout
//   DONE  | result/bus error visible for one cycle, EX/MEM advances
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock__i,
  input  logic        reset_n__i,
  input  logic        MemRead__i,
  input  logic        MemWrite__i,
  input  logic [1:0]  MemSize__i,
  input  logic        MemSigned__i,
  input  logic [31:0] ALUData__i,
  input  logic [31:0] StoreData__i,
  input  logic        RegWrite__i,
  input  logic        MemToReg__i,
  input  logic [4:0]  WBReg__i,
  output logic        RegWrite__o,
  output logic        MemToReg__o,
  output logic [31:0] MemReadData__o,
  output logic [31:0] ALUData__o,
  output logic [4:0]  WBReg__o,
  output logic        Stall__o,
  output logic        Misalign__o,
  output logic        BusErr__o,
  output logic        DMemReq__o,
  output logic        DMemWe__o,
  output logic [31:0] DMemAddr__o,
  output logic [3:0]  DMemBe__o,
  output logic [31:0] DMemWData__o,
  input  logic        DMemAck__i,
  input  logic [31:0] DMemRData__i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic          signed_q;
  logic [31:0]   rdata_q;
  logic          bus_err_q;

  logic          mem_op, is_half, is_word, mis, access;
  logic          stall, launch, finish_ack, finish_to, timeout_hit;
  logic [3:0]    be_st;
  logic [31:0]   wdata_st;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   rdata_fmt;

  assign mem_op  = MemRead__i | MemWrite__i;
  assign is_half = (MemSize__i == 2'b01);
  assign is_word = MemSize__i[1];
  assign mis     = (is_half & ALUData__i[0]) | (is_word & (|ALUData__i[1:0]));
  assign access  = mem_op & ~mis;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Store lanes: little-endian, data replicated across every lane of its width
  always_comb begin
    be_st    = 4'b0000;
    wdata_st = 32'h0;
    if (is_word) begin
      be_st    = 4'b1111;
      wdata_st = StoreData__i;
    end else if (is_half) begin
      be_st    = ALUData__i[1] ? 4'b1100 : 4'b0011;
      wdata_st = {2{StoreData__i[15:0]}};
    end else begin
      be_st    = 4'b0001 << ALUData__i[1:0];
      wdata_st = {4{StoreData__i[7:0]}};
    end
  end

  // Load formatting uses the size/lane latched at launch
  always_comb begin
    ld_byte   = DMemRData__i[{lane_q, 3'b000} +: 8];
    ld_half   = lane_q[1] ? DMemRData__i[31:16] : DMemRData__i[15:0];
    rdata_fmt = DMemRData__i;
    if (!size_q[1]) begin
      if (size_q[0])
        rdata_fmt = {{16{signed_q & ld_half[15]}}, ld_half};
      else
        rdata_fmt = {{24{signed_q & ld_byte[7]}}, ld_byte};
    end
  end

  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    launch     = 1'b0;
    finish_ack = 1'b0;
    finish_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          launch  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (DMemAck__i) begin
          finish_ack = 1'b1;
          state_d    = DONE;
        end else if (timeout_hit) begin
          finish_to = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      DMemReq__o   <= 1'b0;
      DMemWe__o    <= 1'b0;
      DMemAddr__o  <= 32'h0;
      DMemBe__o    <= 4'h0;
      DMemWData__o <= 32'h0;
      cnt_q        <= '0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      signed_q     <= 1'b0;
      rdata_q      <= 32'h0;
      bus_err_q    <= 1'b0;
    end else begin
      if (launch) begin
        DMemReq__o   <= 1'b1;
        DMemWe__o    <= MemWrite__i;
        DMemAddr__o  <= {ALUData__i[31:2], 2'b00};
        DMemBe__o    <= MemWrite__i ? be_st : 4'h0;
        DMemWData__o <= MemWrite__i ? wdata_st : 32'h0;
        cnt_q        <= '0;
        size_q       <= MemSize__i;
        lane_q       <= ALUData__i[1:0];
        signed_q     <= MemSigned__i;
      end else if (state_q == REQ) begin
        if (cnt_q != {CW{1'b1}})
          cnt_q <= cnt_q + CW'(1);
        if (finish_ack) begin
          DMemReq__o <= 1'b0;
          rdata_q    <= rdata_fmt;
        end else if (finish_to) begin
          DMemReq__o <= 1'b0;
          rdata_q    <= 32'h0;
          bus_err_q  <= 1'b1;
        end
      end else if (state_q == DONE) begin
        bus_err_q <= 1'b0;
      end
    end
  end

  assign Stall__o       = stall;
  assign Misalign__o    = mem_op & mis;
  assign BusErr__o      = bus_err_q;
  assign MemReadData__o = rdata_q;
  assign RegWrite__o    = RegWrite__i & ~stall & ~Misalign__o & ~bus_err_q;
  assign MemToReg__o    = MemToReg__i;
  assign ALUData__o     = ALUData__i;
  assign WBReg__o       = WBReg__i;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed and random loads/stores against a
// transaction-level model of lanes, extension, stalls and timeout.
module tb_mem_stage_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, mem_signed, reg_write, mem_to_reg;
  logic [1:0]  mem_size;
  logic [31:0] alu_data, store_data;
  logic [4:0]  wb_reg;
  logic        reg_write_o, mem_to_reg_o, stall, misalign, bus_err;
  logic [31:0] read_data, alu_data_o;
  logic [4:0]  wb_reg_o;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clock__i(clk), .reset_n__i(rst_n),
    .MemRead__i(mem_read), .MemWrite__i(mem_write), .MemSize__i(mem_size),
    .MemSigned__i(mem_signed), .ALUData__i(alu_data), .StoreData__i(store_data),
    .RegWrite__i(reg_write), .MemToReg__i(mem_to_reg), .WBReg__i(wb_reg),
    .RegWrite__o(reg_write_o), .MemToReg__o(mem_to_reg_o), .MemReadData__o(read_data),
    .ALUData__o(alu_data_o), .WBReg__o(wb_reg_o), .Stall__o(stall),
    .Misalign__o(misalign), .BusErr__o(bus_err), .DMemReq__o(dmem_req),
    .DMemWe__o(dmem_we), .DMemAddr__o(dmem_addr), .DMemBe__o(dmem_be),
    .DMemWData__o(dmem_wdata), .DMemAck__i(dmem_ack), .DMemRData__i(dmem_rdata)
  );

  function automatic logic [31:0] load_ref(input logic [1:0] sz, input logic sgn,
                                           input logic [1:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (sz >= 2) return r;
    if (sz == 1) begin
      v = (a >= 2) ? (r >> 16) : (r & 32'hFFFF);
      if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = (r >> (8 * a)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [3:0] be_ref(input logic wr, input logic [1:0] sz, input logic [1:0] a);
    if (!wr) return 4'h0;
    if (sz >= 2) return 4'hF;
    if (sz == 1) return (a >= 2) ? 4'hC : 4'h3;
    return 4'(1 << a);
  endfunction

  function automatic logic [31:0] wd_ref(input logic wr, input logic [1:0] sz, input logic [31:0] d);
    if (!wr) return 32'h0;
    if (sz >= 2) return d;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return (d & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic mis_ref(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 1 && (a % 2) == 1) || (sz >= 2 && a != 0);
  endfunction

  // One complete instruction through the stage; ack_at is the REQ cycle (1-based)
  // that carries the ack, anything outside 1..TO means the bus never answers.
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rword, input int ack_at, input logic rw);
    logic        mis, acked, exp_err;
    logic [4:0]  wb;
    logic [31:0] exp_rd;
    int          k;
    mis = mis_ref(sz, addr[1:0]);
    wb  = 5'($urandom);
    @(negedge clk);
    mem_read = !wr; mem_write = wr; mem_size = sz; mem_signed = sgn;
    alu_data = addr; store_data = sdata; reg_write = rw; mem_to_reg = !wr;
    wb_reg = wb; dmem_ack = 1'b0; dmem_rdata = $urandom;
    #1;
    vectors++;
    if ({stall, misalign, dmem_req, reg_write_o, bus_err} !== {!mis, mis, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle addr=%h stall/mis/req/rw/err got %b want %b", addr,
               {stall, misalign, dmem_req, reg_write_o, bus_err}, {!mis, mis, 3'b000});
    end
    if (mis) begin
      @(posedge clk); #1;
      vectors++;
      if ({dmem_req, stall} !== 2'b00) begin
        miscompares++;
        $display("FAIL misalign_noreq addr=%h req/stall got %b want 00", addr, {dmem_req, stall});
      end
      return;
    end
    acked = 1'b0;
    k = 0;
    while (!acked && k < TO) begin
      @(negedge clk);
      k++;
      dmem_ack   = (k == ack_at);
      dmem_rdata = dmem_ack ? rword : $urandom;
      #1;
      vectors++;
      if ({stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
          {1'b1, 1'b1, wr, addr[31:2], 2'b00, be_ref(wr, sz, addr[1:0]), wd_ref(wr, sz, sdata)}) begin
        miscompares++;
        $display("FAIL req_bus cyc=%0d stall=%b req=%b we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                 k, stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wr,
                 {addr[31:2], 2'b00}, be_ref(wr, sz, addr[1:0]), wd_ref(wr, sz, sdata));
      end
      acked = dmem_ack;
    end
    exp_err = !acked;
    exp_rd  = acked ? load_ref(sz, sgn, addr[1:0], rword) : 32'h0;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    vectors++;
    if ({stall, dmem_req, bus_err, reg_write_o} !== {1'b0, 1'b0, exp_err, rw & !exp_err}) begin
      miscompares++;
      $display("FAIL done stall/req/err/rw got %b want %b", {stall, dmem_req, bus_err, reg_write_o},
               {2'b00, exp_err, rw & !exp_err});
    end
    if (!wr) begin
      vectors++;
      if (read_data !== exp_rd) begin
        miscompares++;
        $display("FAIL load_data addr=%h sz=%0d sgn=%b got %h want %h", addr, sz, sgn, read_data, exp_rd);
      end
    end
    vectors++;
    if ({mem_to_reg_o, alu_data_o, wb_reg_o} !== {!wr, addr, wb}) begin
      miscompares++;
      $display("FAIL passthru got %b/%h/%0d want %b/%h/%0d", mem_to_reg_o, alu_data_o, wb_reg_o, !wr, addr, wb);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_read = 0; mem_write = 0; mem_size = 0; mem_signed = 0;
    alu_data = 0; store_data = 0; reg_write = 0; mem_to_reg = 0; wb_reg = 0;
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, read_data, bus_err, stall} !== '0) begin
      miscompares++;
      $display("FAIL reset req=%b we=%b addr=%h be=%b wd=%h rd=%h err=%b stall=%b", dmem_req, dmem_we,
               dmem_addr, dmem_be, dmem_wdata, read_data, bus_err, stall);
    end
    @(negedge clk);
    rst_n = 1'b1; reg_write = 1'b1; alu_data = 32'hDEAD_BEEF; wb_reg = 5'd9;
    #1;
    vectors++;
    if ({reg_write_o, stall, misalign, alu_data_o, wb_reg_o} !== {3'b100, 32'hDEAD_BEEF, 5'd9}) begin
      miscompares++;
      $display("FAIL passthru_idle rw=%b stall=%b mis=%b alu=%h wb=%0d", reg_write_o, stall, misalign,
               alu_data_o, wb_reg_o);
    end
  endtask

  task automatic test_directed;
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2, 1'b1);
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 1, 1'b1);
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56A5, 32'h0, 3, 1'b0);
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 32'h1111_2222, 1, 1'b1);
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_4001, 32'h5555_6666, 32'h0, 1, 1'b0);
    run_access(1'b0, 2'b11, 1'b1, 32'h0000_4100, 32'h0, 32'hCAFE_F00D, TO, 1'b1);
  endtask

  task automatic test_timeout;
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 32'h7777_7777, 0, 1'b1);
    run_access(1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'h0BAD_0BAD, 32'h0, 0, 1'b0);
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_5007, 32'h0, 32'h00AB_CDEF, 1, 1'b1);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    mem_read = 1; mem_write = 0; mem_size = 2'b10; alu_data = 32'h0000_6000; reg_write = 1;
    @(negedge clk);
    #1;
    vectors++;
    if (dmem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre req got %b want 1", dmem_req);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({dmem_req, bus_err, read_data} !== '0) begin
      miscompares++;
      $display("FAIL midrst_drop req=%b err=%b rd=%h want all 0", dmem_req, bus_err, read_data);
    end
    @(negedge clk);
    mem_read = 0; rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if ({stall, dmem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL late_ack stall/req got %b want 00", {stall, dmem_req});
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    vectors++;
    if ({dmem_req, bus_err, read_data} !== '0) begin
      miscompares++;
      $display("FAIL late_ack_after req=%b err=%b rd=%h want all 0", dmem_req, bus_err, read_data);
    end
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_7002, 32'h0, 32'h8001_0000, 1, 1'b1);
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_7005, 32'h0, 32'h0000_C300, 1, 1'b1);
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_7002, 32'h0000_BEEF, 32'h0, 2, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int ack_at;
      ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
      run_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                 ack_at, 1'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_mid_reset;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
